// File: rtl/pasc_collector_pkg.sv
// pasc_collector_pkg: shared record layout and overflow-counter constants for the PASC output collector.
package pasc_collector_pkg;
  localparam int DEF_CORE_ID_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int OVF_CNT_WIDTH = 16;
  localparam logic [OVF_CNT_WIDTH-1:0] OVF_SAT = 16'hFFFF;
  typedef struct packed {
    logic [DEF_CORE_ID_WIDTH-1:0] core_id;
    logic [DEF_DATA_WIDTH-1:0] data;
  } rec_t;
endpackage

// File: rtl/pasc_sync_fifo_ram.sv
// pasc_sync_fifo_ram: simple dual-port record store with one write port and a registered read port.
module pasc_sync_fifo_ram #(
  parameter int DEPTH = 64,
  parameter int W = 20,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // Read register holds the last popped record; a same-address write returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pasc_output_collector.sv
// pasc_output_collector: captures PASC core results into a FIFO drained by a pop-strobe read port.
module pasc_output_collector import pasc_collector_pkg::*; #(
  parameter int NUM_CORES = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 64,
  localparam int CORE_ID_WIDTH = $clog2(NUM_CORES),
  localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic                     output_enable,
  input  logic [CORE_ID_WIDTH-1:0] output_core_id,
  input  logic [DATA_WIDTH-1:0]    output_data_val,
  input  logic                     clear,
  input  logic                     pop,
  output logic                     rd_valid,
  output logic [CORE_ID_WIDTH-1:0] rd_core_id,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [LEVEL_WIDTH-1:0]   level,
  output logic [OVF_CNT_WIDTH-1:0] overflow_count,
  output logic                     underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef struct packed {
    logic [CORE_ID_WIDTH-1:0] core_id;
    logic [DATA_WIDTH-1:0] data;
  } rec_w_t;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [OVF_CNT_WIDTH-1:0] ovf_q, ovf_d;
  logic unf_q, unf_d, rv_q, rv_d;
  logic push_ok, pop_ok, drop;
  rec_w_t wrec, rrec;
  assign level = wr_q - rd_q;
  assign empty = wr_q == rd_q;
  assign full = level == LEVEL_WIDTH'(FIFO_DEPTH);
  assign pop_ok = pop & ~empty & ~clear;
  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  assign push_ok = output_enable & ~clear & (~full | pop_ok);
  assign drop = output_enable & ~clear & full & ~pop_ok;
  assign wrec = '{core_id: output_core_id, data: output_data_val};
  always_comb begin
    wr_d = clear ? '0 : wr_q + {{AW{1'b0}}, push_ok};
    rd_d = clear ? '0 : rd_q + {{AW{1'b0}}, pop_ok};
    ovf_d = clear ? '0 : (drop && ovf_q != OVF_SAT) ? ovf_q + 16'd1 : ovf_q;
    unf_d = ~clear & (unf_q | (pop & empty));
    rv_d = pop_ok;
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= '0;
      unf_q <= 1'b0;
      rv_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      rv_q <= rv_d;
    end
  end
  pasc_sync_fifo_ram #(.DEPTH(FIFO_DEPTH), .W(CORE_ID_WIDTH + DATA_WIDTH)) u_ram (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .we    (push_ok),
    .waddr (wr_q[AW-1:0]),
    .wdata (wrec),
    .re    (pop_ok),
    .raddr (rd_q[AW-1:0]),
    .rdata (rrec)
  );
  assign rd_valid = rv_q;
  assign rd_core_id = rrec.core_id;
  assign rd_data = rrec.data;
  assign overflow_count = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_pasc_output_collector.sv
// tb_pasc_output_collector: queue-model bench with directed vectors for the PASC output collector.
module tb_pasc_output_collector;
  localparam int DEPTH = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, clr = 1'b0, pp = 1'b0;
  logic [3:0] cid = '0;
  logic [15:0] dat = '0;
  logic rd_valid, empty, full, underflow;
  logic [3:0] rd_core_id;
  logic [15:0] rd_data, overflow_count;
  logic [6:0] level;
  int checks = 0, errors = 0;

  pasc_output_collector dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .output_enable(en), .output_core_id(cid),
    .output_data_val(dat), .clear(clr), .pop(pp), .rd_valid(rd_valid), .rd_core_id(rd_core_id),
    .rd_data(rd_data), .empty(empty), .full(full), .level(level),
    .overflow_count(overflow_count), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {logic [3:0] c; logic [15:0] d;} mrec_t;
  mrec_t q[$];
  logic [15:0] m_ovf = '0;
  logic m_unf = 1'b0, m_rv = 1'b0;
  logic [3:0] m_rc = '0;
  logic [15:0] m_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); m_ovf = '0; m_unf = 1'b0; m_rv = 1'b0; m_rc = '0; m_rd = '0;
    end else if (clr) begin
      q.delete(); m_ovf = '0; m_unf = 1'b0; m_rv = 1'b0;
    end else begin
      automatic bit was_full = q.size() == DEPTH;
      automatic bit popped = pp && q.size() > 0;
      mrec_t r;
      if (pp && !popped) m_unf = 1'b1;
      m_rv = popped;
      if (popped) begin r = q.pop_front(); m_rc = r.c; m_rd = r.d; end
      if (en) begin
        if (!was_full || popped) q.push_back('{cid, dat});
        else if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("level", level, q.size());
    chk("overflow_count", overflow_count, m_ovf);
    chk("underflow", underflow, m_unf);
    chk("rd_valid", rd_valid, m_rv);
    chk("rd_core_id", rd_core_id, m_rc);
    chk("rd_data", rd_data, m_rd);
  end

  task automatic drive(input logic e, input logic [3:0] c, input logic [15:0] d, input logic p, input logic cl);
    en = e; cid = c; dat = d; pp = p; clr = cl;
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("reset_empty", empty, 1);
    chk("reset_level", level, 0);
    chk("reset_rd_valid", rd_valid, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    drive(1, 3, 16'h1234, 0, 0);
    drive(1, 15, 16'hBEEF, 0, 0);
    chk("lvl_after_2_push", level, 2);
    drive(0, 0, 0, 1, 0);
    chk("pop1_valid", rd_valid, 1);
    chk("pop1_rec", {rd_core_id, rd_data}, {4'd3, 16'h1234});
    chk("pop1_level", level, 1);
    drive(0, 0, 0, 1, 0);
    chk("pop2_rec", {rd_core_id, rd_data}, {4'd15, 16'hBEEF});
    chk("pop2_level", level, 0);
    drive(0, 0, 0, 0, 0);
    chk("pop_pulse_end", rd_valid, 0);
    chk("empty_after_pops", empty, 1);
    for (int i = 0; i < DEPTH; i++) drive(1, 4'(i % 16), 16'(i), 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 4'd1, 16'hFFFF, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_level", level, 64);
    chk("fill_ovf", overflow_count, 3);
    drive(1, 5, 16'hAAAA, 1, 0);
    chk("fullpp_level", level, 64);
    chk("fullpp_ovf", overflow_count, 3);
    chk("fullpp_data", rd_data, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      drive(0, 0, 0, 1, 0);
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, i == DEPTH ? 32'hAAAA : 32'(i));
    end
    chk("drained_empty", empty, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("unf_valid", rd_valid, 0);
    chk("unf_set", underflow, 1);
    drive(0, 0, 0, 0, 1);
    chk("clr_unf", underflow, 0);
    chk("clr_ovf", overflow_count, 0);
    chk("clr_hold_data", rd_data, 16'hAAAA);
    drive(1, 7, 16'h0077, 1, 0);
    chk("pp_empty_valid", rd_valid, 0);
    chk("pp_empty_unf", underflow, 1);
    chk("pp_empty_level", level, 1);
    drive(1, 1, 16'h0001, 1, 1);
    chk("clr2_level", level, 0);
    chk("clr2_unf", underflow, 0);
    chk("clr2_ovf", overflow_count, 0);
    for (int i = 0; i < DEPTH; i++) drive(1, 4'(i), 16'(i), 0, 0);
    for (int i = 0; i < 65600; i++) drive(1, 4'd2, 16'h2222, 0, 0);
    chk("sat_ovf", overflow_count, 16'hFFFF);
    chk("sat_full", full, 1);
    drive(0, 0, 0, 0, 1);
    chk("sat_clr_ovf", overflow_count, 0);
    for (int i = 0; i < 10; i++) drive(1, 4'(i), 16'h100 + 16'(i), 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 4'd8, 16'h0108, 0, 0);
    chk("pre_rst_level", level, 10);
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_rd_valid", rd_valid, 0);
    en = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    drive(1, 9, 16'h5A5A, 0, 0);
    chk("post_rst_level", level, 1);
    drive(0, 0, 0, 1, 0);
    chk("post_rst_rec", {rd_valid, rd_core_id, rd_data}, {1'b1, 4'd9, 16'h5A5A});
    drive(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
